detector_nota: RTL and testbench
================================

# detector_nota

Tone decoder for the game's audio path: receives the note pulse train produced by the buzzer tone generator (one clock-wide pulse every half note period), measures the spacing between pulses and reports which of the four notes (DO, RE, SOL, LA) is present, using the same one-hot encoding as the generator's selector. Used for loopback self-test and for reading tones from an external source. A note is reported only after several consecutive matching intervals.

## Interface
- CLOCK_FREQ, 50_000_000: clock frequency in Hz.
- TOL_SHIFT, 5: tolerance per note is N_k >> TOL_SHIFT cycles.
- CONFIRMA, 4: consecutive intervals of the same class needed to update `nota`.
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- habilita  in  1  enable; low clears measurement state and outputs, same as reset.
- entrada  in  1  asynchronous pulse/square input.
- nota  out  4  one-hot note: 1000 DO, 0010 RE, 0001 SOL, 0100 LA, 0000 none.
- valida  out  1  high while `nota` != 0000.
- nova  out  1  one-cycle pulse when `nota` changes value.
- periodo  out  W  last measured interval in cycles; W = $clog2(2*N_DO+1).

## Operation
- Nominal interval N_k = (CLOCK_FREQ/F_k)/2, F = 264/300/396/440 Hz, integer division.
- `entrada` passes a 2-flop synchronizer, then rising-edge detect.
- Interval counter: loaded with 1 on a detected edge, +1 on every other cycle, saturates at 2*N_DO. Value at an edge = cycles between consecutive edges.
- First edge after reset/habilita/timeout only arms the counter (flag `armado`); no interval produced.
- Each later edge: `periodo` <= counter; class = note k with |counter - N_k| <= N_k >> TOL_SHIFT, else 0000 (ranges never overlap for legal parameters).
- Confirmation: if class == candidate, match count +1 (saturating at CONFIRMA); else candidate <= class, count <= 1. When count == CONFIRMA and candidate != nota: nota <= candidate, nova = 1 for that cycle. 0000 is a valid candidate (unknown tone clears `nota` after CONFIRMA intervals).
- Alternating classes never confirm; `nota` holds its value.
- Timeout (macro-dependent): counter reaching 2*N_DO without an edge.
- Reset/habilita low: nota 0000, valida 0, nova 0, periodo 0, counter 0, armado 0, candidate 0000, count 0. Takes effect the next clock edge, mid-train included.

## Timing
- Synchronizer 2 cycles, edge detect/interval capture 1 cycle, confirmation register 1 cycle: `nota`/`valida`/`nova` change 4 clocks after the clock edge that first samples `entrada` high on the confirming pulse.
- `periodo` updates 3 clocks after that sampling edge.
- `valida` is registered alongside `nota`, never disagrees with it.
- Edge coincident with timeout cycle: edge wins (interval = 2*N_DO, classified normally, no timeout).

## Configuration
- DETECTOR_NOTA_TIMEOUT_EN defined: when the counter reaches 2*N_DO, nota <= 0000, valida 0, nova pulses if nota was non-zero, armado/candidate/count cleared.
- Not defined: counter saturates silently; `nota` holds last confirmed note indefinitely; next edge yields interval 2*N_DO (class 0000).

## Structure
- Package detector_nota_pkg: note frequencies, one-hot note codes (shared with the tone generator), function computing N_k from CLOCK_FREQ.
- Sub-module sincronizador_borda: 2-flop synchronizer plus registered rising-edge pulse, with synchronous reset.

## Test plan
- CLOCK_FREQ=100_000 (N: DO 189, RE 166, SOL 126, LA 113; tolerances 5/5/3/3). 6 pulses spaced 189 cycles -> after 5th pulse nota=1000, valida=1, one nova pulse, periodo=189.
- From DO, switch to 113 spacing -> nota stays 1000 for 3 intervals, becomes 0100 on 4th, nova once.
- Tolerance: 4 intervals of 194 -> 1000; then 4 intervals of 195 -> nota 0000, valida 0, nova pulse.
- Stop pulses with TIMEOUT_EN -> 378 cycles after last edge nota=0000, nova pulse; without macro nota stays 1000.
- Alternating 126/166 intervals for 20 pulses from reset -> nota 0000, nova never asserted.
- Reset mid-train at LA -> all outputs 0 next cycle; after release 5 pulses at 113 required before nota=0100.

Source files
------------

// File: rtl/detector_nota_pkg.sv
// detector_nota_pkg
// Shared definitions for the tone decoder:
//   - note frequencies (Hz) of DO, RE, SOL, LA
//   - one-hot note codes, identical to the tone generator's selector encoding
//   - calc_n(): nominal half-period in clock cycles for a given note
//   - classifica(): maps a measured interval to a one-hot note code (0000 = none)
//   - estado_t: arming state of the interval measurement
package detector_nota_pkg;

    localparam int FREQ_DO  = 264;
    localparam int FREQ_RE  = 300;
    localparam int FREQ_SOL = 396;
    localparam int FREQ_LA  = 440;

    localparam logic [3:0] NOTA_NENHUMA = 4'b0000;
    localparam logic [3:0] NOTA_DO      = 4'b1000;
    localparam logic [3:0] NOTA_RE      = 4'b0010;
    localparam logic [3:0] NOTA_SOL     = 4'b0001;
    localparam logic [3:0] NOTA_LA      = 4'b0100;

    // ST_ESPERA: next edge only arms the counter; ST_ARMADO: next edge closes an interval.
    typedef enum logic {
        ST_ESPERA = 1'b0,
        ST_ARMADO = 1'b1
    } estado_t;

    // Pulse spacing of the generator is half the note period.
    function automatic int calc_n(input int clock_freq, input int freq);
        return (clock_freq / freq) / 2;
    endfunction

    function automatic logic dentro_tol(input int intervalo, input int n, input int tol_shift);
        int diff;
        diff = intervalo - n;
        if (diff < 0) diff = -diff;
        return diff <= (n >> tol_shift);
    endfunction

    // Tolerance windows never overlap for legal parameters, so the order of the tests is irrelevant.
    function automatic logic [3:0] classifica(input int intervalo, input int clock_freq,
                                              input int tol_shift);
        logic [3:0] c;
        c = NOTA_NENHUMA;
        if (dentro_tol(intervalo, calc_n(clock_freq, FREQ_DO),  tol_shift)) c = NOTA_DO;
        if (dentro_tol(intervalo, calc_n(clock_freq, FREQ_RE),  tol_shift)) c = NOTA_RE;
        if (dentro_tol(intervalo, calc_n(clock_freq, FREQ_SOL), tol_shift)) c = NOTA_SOL;
        if (dentro_tol(intervalo, calc_n(clock_freq, FREQ_LA),  tol_shift)) c = NOTA_LA;
        return c;
    endfunction

endpackage

// File: rtl/detector_nota_sincronizador_borda.sv
// sincronizador_borda
// Two-flop synchronizer for the asynchronous input followed by a registered
// rising-edge detector. Latency: borda is high for one cycle, two clocks after
// the edge that first samples entrada high into the first stage.
// Ports:
//   clock   in  system clock
//   limpa   in  synchronous clear (active high), empties the whole pipeline
//   entrada in  asynchronous input
//   borda   out one-cycle pulse per rising edge of entrada
module sincronizador_borda (
    input  logic clock,
    input  logic limpa,
    input  logic entrada,
    output logic borda
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic borda_q, borda_d;

    always_comb begin
        s1_d    = entrada;
        s2_d    = s1_q;
        s3_d    = s2_q;
        borda_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clock) begin
        if (limpa) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            borda_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            borda_q <= borda_d;
        end
    end

    assign borda = borda_q;

endmodule

// File: rtl/detector_nota.sv
// detector_nota
// Tone decoder: measures the spacing between pulses of the note pulse train and
// reports which note (DO, RE, SOL, LA) is present once CONFIRMA consecutive
// intervals agree. Optional feature macro: DETECTOR_NOTA_TIMEOUT_EN (clears the
// note when no edge arrives for 2*N_DO cycles).
// Ports:
//   clock    in  system clock
//   reset    in  synchronous active-high reset
//   habilita in  enable; low behaves like reset
//   entrada  in  asynchronous pulse/square input
//   nota     out one-hot note (1000 DO, 0010 RE, 0001 SOL, 0100 LA, 0000 none)
//   valida   out high while nota is non-zero
//   nova     out one-cycle pulse when nota changes
//   periodo  out last measured interval in cycles
module detector_nota
    import detector_nota_pkg::*;
#(
    parameter  int CLOCK_FREQ = 50_000_000,
    parameter  int TOL_SHIFT  = 5,
    parameter  int CONFIRMA   = 4,
    localparam int W          = $clog2(2 * calc_n(CLOCK_FREQ, FREQ_DO) + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         habilita,
    input  logic         entrada,
    output logic [3:0]   nota,
    output logic         valida,
    output logic         nova,
    output logic [W-1:0] periodo
);

    localparam int             CW      = $clog2(CONFIRMA + 1);
    localparam logic [W-1:0]   CNT_MAX = W'(2 * calc_n(CLOCK_FREQ, FREQ_DO));
    localparam logic [CW-1:0]  CONF_L  = CW'(CONFIRMA);

    logic limpa;
    logic borda;

    assign limpa = reset || !habilita;

    sincronizador_borda u_sinc (
        .clock   (clock),
        .limpa   (limpa),
        .entrada (entrada),
        .borda   (borda)
    );

    estado_t         estado_q, estado_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    periodo_q, periodo_d;
    logic [3:0]      classe_q, classe_d;
    logic            int_valid_q, int_valid_d;
    logic [3:0]      cand_q, cand_d;
    logic [CW-1:0]   conta_q, conta_d;
    logic [3:0]      nota_q, nota_d;
    logic            valida_q, valida_d;
    logic            nova_q, nova_d;

    always_comb begin
        estado_d    = estado_q;
        periodo_d   = periodo_q;
        classe_d    = classe_q;
        int_valid_d = 1'b0;
        cand_d      = cand_q;
        conta_d     = conta_q;
        nota_d      = nota_q;
        nova_d      = 1'b0;

        // Interval counter: value seen at an edge equals cycles since the previous edge.
        if (borda) begin
            cnt_d = W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Confirmation stage: consumes the interval classified on the previous cycle.
        if (int_valid_q) begin
            if (classe_q == cand_q) begin
                if (conta_q != CONF_L) conta_d = conta_q + 1'b1;
            end else begin
                cand_d  = classe_q;
                conta_d = CW'(1);
            end
            if (conta_d == CONF_L && cand_d != nota_q) begin
                nota_d = cand_d;
                nova_d = 1'b1;
            end
        end

        // Capture stage; an edge on the saturation cycle takes priority over the timeout.
        if (borda) begin
            if (estado_q == ST_ARMADO) begin
                periodo_d   = cnt_q;
                classe_d    = classifica(int'(cnt_q), CLOCK_FREQ, TOL_SHIFT);
                int_valid_d = 1'b1;
            end
            estado_d = ST_ARMADO;
        end
`ifdef DETECTOR_NOTA_TIMEOUT_EN
        else if (estado_q == ST_ARMADO && cnt_q == CNT_MAX) begin
            estado_d = ST_ESPERA;
            cand_d   = NOTA_NENHUMA;
            conta_d  = '0;
            nota_d   = NOTA_NENHUMA;
            nova_d   = (nota_q != NOTA_NENHUMA);
        end
`endif

        valida_d = (nota_d != NOTA_NENHUMA);
    end

    always_ff @(posedge clock) begin
        if (limpa) begin
            estado_q    <= ST_ESPERA;
            cnt_q       <= '0;
            periodo_q   <= '0;
            classe_q    <= NOTA_NENHUMA;
            int_valid_q <= 1'b0;
            cand_q      <= NOTA_NENHUMA;
            conta_q     <= '0;
            nota_q      <= NOTA_NENHUMA;
            valida_q    <= 1'b0;
            nova_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            periodo_q   <= periodo_d;
            classe_q    <= classe_d;
            int_valid_q <= int_valid_d;
            cand_q      <= cand_d;
            conta_q     <= conta_d;
            nota_q      <= nota_d;
            valida_q    <= valida_d;
            nova_q      <= nova_d;
        end
    end

    assign nota    = nota_q;
    assign valida  = valida_q;
    assign nova    = nova_q;
    assign periodo = periodo_q;

endmodule

// File: tb/tb_detector_nota.sv
// tb_detector_nota
// Bench for detector_nota with CLOCK_FREQ=100_000 (N: DO 189, RE 166, SOL 126, LA 113).
// Inputs change on the falling edge; outputs are compared on the falling edge
// against an event-level model of the decoder.
module tb_detector_nota;

  localparam int CLOCK_FREQ = 100_000;
  localparam int TOL_SHIFT  = 5;
  localparam int CONFIRMA   = 4;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic       entrada;
  logic [3:0] nota;
  logic       valida;
  logic       nova;
  logic [8:0] periodo;

  detector_nota #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TOL_SHIFT  (TOL_SHIFT),
    .CONFIRMA   (CONFIRMA)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .entrada  (entrada),
    .nota     (nota),
    .valida   (valida),
    .nova     (nova),
    .periodo  (periodo)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters ----------------
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned nova_cnt   = 0;
  int unsigned cyc        = 0;
  bit          chk_en     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_of(input int k);
    int f;
    case (k)
      0: f = 264;
      1: f = 300;
      2: f = 396;
      default: f = 440;
    endcase
    return (CLOCK_FREQ / f) / 2;
  endfunction

  function automatic logic [3:0] code_of(input int k);
    case (k)
      0: return 4'b1000;
      1: return 4'b0010;
      2: return 4'b0001;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic [3:0] classify(input int iv);
    logic [3:0] c;
    int d;
    c = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      d = iv - n_of(k);
      if (d < 0) d = -d;
      if (d <= (n_of(k) >> TOL_SHIFT)) c = code_of(k);
    end
    return c;
  endfunction

  localparam int MAXI = 2 * ((CLOCK_FREQ / 264) / 2);

  // Model state: scheduled capture times of sampled rising edges, arming, and the
  // candidate / confirmation bookkeeping.
  int         cap_q[$];
  bit         s_prev;
  bit         armed;
  int         last_cap;
  bit         conf_pend;
  int         conf_at;
  logic [3:0] conf_cls;
  logic [3:0] m_cand;
  int         m_cnt;
  logic [3:0] m_nota;
  bit         m_nova;
  int         m_periodo;

  always @(posedge clock) begin
    int iv;
    cyc++;
    if (reset || !habilita) begin
      cap_q.delete();
      s_prev    = 0;
      armed     = 0;
      last_cap  = 0;
      conf_pend = 0;
      m_cand    = 4'b0000;
      m_cnt     = 0;
      m_nota    = 4'b0000;
      m_nova    = 0;
      m_periodo = 0;
      chk_en    = 1;
    end else begin
      m_nova = 0;
      if (conf_pend && conf_at == int'(cyc)) begin
        conf_pend = 0;
        if (conf_cls == m_cand) begin
          if (m_cnt < CONFIRMA) m_cnt++;
        end else begin
          m_cand = conf_cls;
          m_cnt  = 1;
        end
        if (m_cnt == CONFIRMA && m_cand != m_nota) begin
          m_nota = m_cand;
          m_nova = 1;
        end
      end
      if (cap_q.size() > 0 && cap_q[0] == int'(cyc)) begin
        void'(cap_q.pop_front());
        if (armed) begin
          iv = int'(cyc) - last_cap;
          if (iv > MAXI) iv = MAXI;
          m_periodo = iv;
          conf_cls  = classify(iv);
          conf_pend = 1;
          conf_at   = int'(cyc) + 1;
        end
        armed    = 1;
        last_cap = int'(cyc);
      end
`ifdef DETECTOR_NOTA_TIMEOUT_EN
      else if (armed && int'(cyc) - last_cap >= MAXI) begin
        armed  = 0;
        m_cand = 4'b0000;
        m_cnt  = 0;
        if (m_nota != 4'b0000) begin
          m_nota = 4'b0000;
          m_nova = 1;
        end
      end
`endif
      // Two synchronizer stages plus the edge register: capture three clocks after sampling.
      if (entrada && !s_prev) cap_q.push_back(int'(cyc) + 3);
      s_prev = entrada;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("nota",    32'(nota),    32'(m_nota));
      check("valida",  32'(valida),  32'(m_nota != 4'b0000));
      check("nova",    32'(nova),    32'(m_nova));
      check("periodo", 32'(periodo), 32'(m_periodo));
      if (nova === 1'b1) nova_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    entrada = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nova_cnt = 0;
  endtask

  task automatic train(input int spacing, input int n, input int width);
    for (int i = 0; i < n; i++) begin
      entrada = 1'b1;
      repeat (width) @(negedge clock);
      entrada = 1'b0;
      repeat (spacing - width) @(negedge clock);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, sp, len, w, tol;
    reset    = 1'b1;
    habilita = 1'b1;
    entrada  = 1'b0;
    @(negedge clock);
    do_reset();

    // Reset state
    check("rst_nota",    32'(nota),    32'd0);
    check("rst_valida",  32'(valida),  32'd0);
    check("rst_periodo", 32'(periodo), 32'd0);

    // DO train
    train(189, 6, 1);
    check("do_nota",     32'(nota),     32'b1000);
    check("do_valida",   32'(valida),   32'd1);
    check("do_periodo",  32'(periodo),  32'd189);
    check("do_nova_cnt", 32'(nova_cnt), 32'd1);
    check("do_model",    32'(m_nota),   32'b1000);

    // DO -> LA: three LA intervals keep DO, fourth switches
    train(113, 4, 1);
    check("la3_nota", 32'(nota), 32'b1000);
    train(113, 1, 1);
    check("la4_nota",    32'(nota),     32'b0100);
    check("la4_periodo", 32'(periodo),  32'd113);
    check("la4_nova",    32'(nova_cnt), 32'd2);
    check("la4_model",   32'(m_nota),   32'b0100);

    // Tolerance edge: 194 inside DO window, 195 outside
    do_reset();
    train(194, 5, 1);
    check("tol194_nota", 32'(nota), 32'b1000);
    train(195, 5, 1);
    check("tol195_nota",   32'(nota),     32'd0);
    check("tol195_valida", 32'(valida),   32'd0);
    check("tol195_nova",   32'(nova_cnt), 32'd2);

    // Silence after DO
    do_reset();
    train(189, 5, 1);
    repeat (400) @(negedge clock);
`ifdef DETECTOR_NOTA_TIMEOUT_EN
    check("silence_nota", 32'(nota),     32'd0);
    check("silence_nova", 32'(nova_cnt), 32'd2);
`else
    check("silence_nota", 32'(nota),     32'b1000);
    check("silence_nova", 32'(nova_cnt), 32'd1);
`endif
    train(189, 5, 1);

    // Alternating SOL/RE intervals never confirm
    do_reset();
    for (int i = 0; i < 10; i++) begin
      train(126, 1, 1);
      train(166, 1, 1);
    end
    check("alt_nota", 32'(nota),     32'd0);
    check("alt_nova", 32'(nova_cnt), 32'd0);

    // Reset in the middle of an LA train
    do_reset();
    train(113, 5, 1);
    check("mid_la_nota", 32'(nota), 32'b0100);
    entrada = 1'b1;
    @(negedge clock);
    entrada = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_nota",    32'(nota),    32'd0);
    check("mid_rst_valida",  32'(valida),  32'd0);
    check("mid_rst_periodo", 32'(periodo), 32'd0);
    reset = 1'b0;
    nova_cnt = 0;
    train(113, 4, 1);
    check("post_rst4_nota", 32'(nota), 32'd0);
    train(113, 1, 1);
    check("post_rst5_nota", 32'(nota), 32'b0100);

    // Randomized bursts, pulse widths and enable drops
    for (int b = 0; b < 40; b++) begin
      k   = $urandom_range(0, 4);
      len = $urandom_range(2, 7);
      w   = $urandom_range(1, 3);
      if (k == 4) begin
        sp = $urandom_range(60, 400);
      end else begin
        tol = n_of(k) >> TOL_SHIFT;
        sp  = n_of(k) - tol - 1 + $urandom_range(0, 2 * tol + 2);
      end
      train(sp, len, w);
      if ($urandom_range(0, 9) == 0) begin
        habilita = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        habilita = 1'b1;
      end
    end

    repeat (8) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
